// File: rtl/seq_detect_param.sv
// Serial bit-pattern detector with a runtime-programmable pattern of 1..MAX_LEN bits.
// Supports overlapping/non-overlapping matches, a registered match pulse and a saturating counter.
module seq_detect_param #(
  parameter int unsigned         MAX_LEN     = 16,
  parameter int unsigned         LW          = 5,
  parameter int unsigned         CNT_W       = 8,
  parameter logic [MAX_LEN-1:0]  DEF_PATTERN = 16'h0072,
  parameter int unsigned         DEF_LEN     = 7,
  parameter bit                  DEF_OVERLAP = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic               in_bit,
  input  logic               cfg_we,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LW-1:0]      cfg_len,
  input  logic               cfg_overlap,
  input  logic               clr_cnt,
  output logic               match,
  output logic [CNT_W-1:0]   match_cnt,
  output logic [LW-1:0]      fill
);

  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LW-1:0]      fill_q, fill_d;
  logic [LW-1:0]      len_q, len_d;
  logic               ovl_q, ovl_d;
  logic               match_q, match_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               accept;
  logic               hit;
  logic [MAX_LEN-1:0] hist_sh;
  logic [MAX_LEN-1:0] len_mask;
  logic [LW-1:0]      fill_inc;

  always_comb begin
    // NOTE: every signal gets a default before any branch so no path leaves it unassigned (no latches).
    hist_d  = hist_q;
    pat_d   = pat_q;
    fill_d  = fill_q;
    len_d   = len_q;
    ovl_d   = ovl_q;
    cnt_d   = cnt_q;

    accept  = in_valid && !cfg_we;
    hist_sh = {hist_q[MAX_LEN-2:0], in_bit};

    // fill never exceeds the active length, so this is min(fill+1, len).
    fill_inc = (fill_q >= len_q) ? len_q : fill_q + LW'(1);

    for (int i = 0; i < MAX_LEN; i++) begin
      len_mask[i] = (LW'(i) < len_q);
    end

    hit = accept && (fill_inc == len_q) && (((hist_sh ^ pat_q) & len_mask) == '0);
    match_d = hit;

    if (cfg_we) begin
      pat_d  = cfg_pattern;
      ovl_d  = cfg_overlap;
      hist_d = '0;
      fill_d = '0;
      if (cfg_len == '0)                 len_d = LW'(1);
      else if (cfg_len > LW'(MAX_LEN))   len_d = LW'(MAX_LEN);
      else                               len_d = cfg_len;
    end else if (accept) begin
      hist_d = hist_sh;
      // Non-overlapping mode restarts the count so the next match needs len fresh bits.
      fill_d = (hit && !ovl_q) ? '0 : fill_inc;
    end

    if (clr_cnt)                cnt_d = '0;
    else if (hit && !(&cnt_q))  cnt_d = cnt_q + CNT_W'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist_q  <= '0;
      fill_q  <= '0;
      pat_q   <= DEF_PATTERN;
      len_q   <= LW'(DEF_LEN);
      ovl_q   <= DEF_OVERLAP;
      match_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      ovl_q   <= ovl_d;
      match_q <= match_d;
      cnt_q   <= cnt_d;
    end
  end

  assign match     = match_q;
  assign match_cnt = cnt_q;
  assign fill      = fill_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench for seq_detect_param: a vector table for the main matching behaviour,
// then hand-written sequences for saturation, clamping, async reset and mid-stream config.
module tb_seq_detect_param;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_bit = 1'b0;
  logic        cfg_we = 1'b0;
  logic [15:0] cfg_pattern = '0;
  logic [4:0]  cfg_len = '0;
  logic        cfg_overlap = 1'b0;
  logic        clr_cnt = 1'b0;
  logic        match;
  logic [7:0]  match_cnt;
  logic [4:0]  fill;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  seq_detect_param dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_bit      (in_bit),
    .cfg_we      (cfg_we),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .clr_cnt     (clr_cnt),
    .match       (match),
    .match_cnt   (match_cnt),
    .fill        (fill)
  );

  typedef struct {
    logic        v;
    logic        b;
    logic        we;
    logic [15:0] pat;
    logic [4:0]  len;
    logic        ovl;
    logic        clr;
    logic        m;
    logic [7:0]  c;
    logic [4:0]  f;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t vd(logic v, logic b, logic m, logic [7:0] c, logic [4:0] f);
    vec_t r;
    r = '{v: v, b: b, we: 1'b0, pat: 16'h0, len: 5'd0, ovl: 1'b0, clr: 1'b0, m: m, c: c, f: f};
    return r;
  endfunction

  function automatic vec_t vc(logic [15:0] pat, logic [4:0] len, logic ovl, logic clr,
                              logic m, logic [7:0] c, logic [4:0] f);
    vec_t r;
    r = '{v: 1'b1, b: 1'b1, we: 1'b1, pat: pat, len: len, ovl: ovl, clr: clr, m: m, c: c, f: f};
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check3(input string tag, input logic m, input logic [7:0] c, input logic [4:0] f);
    check({tag, " match"}, 32'(match), 32'(m));
    check({tag, " cnt"},   32'(match_cnt), 32'(c));
    check({tag, " fill"},  32'(fill), 32'(f));
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled at the same offset.
  task automatic drive(input logic v, input logic b, input logic we, input logic [15:0] p,
                       input logic [4:0] l, input logic o, input logic c);
    in_valid = v; in_bit = b; cfg_we = we; cfg_pattern = p; cfg_len = l; cfg_overlap = o; clr_cnt = c;
    @(posedge clk);
    #1;
    in_valid = 1'b0; cfg_we = 1'b0; clr_cnt = 1'b0;
  endtask

  task automatic bit_in(input logic b);
    drive(1'b1, b, 1'b0, 16'h0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  logic [6:0] def_bits;
  logic       all_hit;

  initial begin
    def_bits = 7'b1110010;

    // Default pattern 1110010, overlap, from reset.
    tbl.push_back(vd(1, 1, 0, 0, 1));
    tbl.push_back(vd(1, 1, 0, 0, 2));
    tbl.push_back(vd(1, 1, 0, 0, 3));
    tbl.push_back(vd(1, 0, 0, 0, 4));
    tbl.push_back(vd(1, 0, 0, 0, 5));
    tbl.push_back(vd(1, 1, 0, 0, 6));
    tbl.push_back(vd(1, 0, 1, 1, 7));
    tbl.push_back(vd(0, 0, 0, 1, 7));
    // Reload default config (bit presented during cfg_we is dropped), then stream with a 3-cycle gap.
    tbl.push_back(vc(16'h0072, 5'd7, 1, 0, 0, 1, 0));
    tbl.push_back(vd(1, 1, 0, 1, 1));
    tbl.push_back(vd(1, 1, 0, 1, 2));
    tbl.push_back(vd(1, 1, 0, 1, 3));
    tbl.push_back(vd(1, 0, 0, 1, 4));
    tbl.push_back(vd(0, 1, 0, 1, 4));
    tbl.push_back(vd(0, 1, 0, 1, 4));
    tbl.push_back(vd(0, 1, 0, 1, 4));
    tbl.push_back(vd(1, 0, 0, 1, 5));
    tbl.push_back(vd(1, 1, 0, 1, 6));
    tbl.push_back(vd(1, 0, 1, 2, 7));
    tbl.push_back(vd(0, 0, 0, 2, 7));
    // Pattern 101, overlapping: stream 1,0,1,0,1 matches twice.
    tbl.push_back(vc(16'h0005, 5'd3, 1, 0, 0, 2, 0));
    tbl.push_back(vd(1, 1, 0, 2, 1));
    tbl.push_back(vd(1, 0, 0, 2, 2));
    tbl.push_back(vd(1, 1, 1, 3, 3));
    tbl.push_back(vd(1, 0, 0, 3, 3));
    tbl.push_back(vd(1, 1, 1, 4, 3));
    // Pattern 101, non-overlapping: same stream matches once.
    tbl.push_back(vc(16'h0005, 5'd3, 0, 0, 0, 4, 0));
    tbl.push_back(vd(1, 1, 0, 4, 1));
    tbl.push_back(vd(1, 0, 0, 4, 2));
    tbl.push_back(vd(1, 1, 1, 5, 0));
    tbl.push_back(vd(1, 0, 0, 5, 1));
    tbl.push_back(vd(1, 1, 0, 5, 2));
    tbl.push_back(vd(0, 0, 0, 5, 2));
    // cfg_we with clr_cnt and len 0 (clamps to 1), pattern 1, non-overlap.
    tbl.push_back(vc(16'h0001, 5'd0, 0, 1, 0, 0, 0));
    tbl.push_back(vd(1, 1, 1, 1, 0));
    tbl.push_back(vd(1, 0, 0, 1, 1));
    tbl.push_back(vd(1, 1, 1, 2, 0));

    // Reset state.
    #2;
    check("reset async match", 32'(match), 32'd0);
    check("reset async cnt",   32'(match_cnt), 32'd0);
    check("reset async fill",  32'(fill), 32'd0);
    do_reset();
    check3("reset", 1'b0, 8'd0, 5'd0);

    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].b, tbl[i].we, tbl[i].pat, tbl[i].len, tbl[i].ovl, tbl[i].clr);
      check3($sformatf("vec%0d", i), tbl[i].m, tbl[i].c, tbl[i].f);
    end

    // Saturation: len 1, pattern 1, 300 ones; every bit hits, count stops at 255.
    drive(1'b0, 1'b0, 1'b1, 16'h0001, 5'd1, 1'b1, 1'b1);
    check3("sat cfg", 1'b0, 8'd0, 5'd0);
    all_hit = 1'b1;
    for (int k = 1; k <= 300; k++) begin
      bit_in(1'b1);
      all_hit &= match;
      if (k == 255) check("sat cnt at 255", 32'(match_cnt), 32'd255);
    end
    check("sat every bit hit", 32'(all_hit), 32'd1);
    check3("sat end", 1'b1, 8'd255, 5'd1);
    // Clear coincident with a hit: pulse still occurs, count goes to 0.
    drive(1'b1, 1'b1, 1'b0, 16'h0, 5'd0, 1'b0, 1'b1);
    check3("clr with hit", 1'b1, 8'd0, 5'd1);

    // Length above MAX_LEN clamps to 16: sixteen ones needed.
    drive(1'b0, 1'b0, 1'b1, 16'hFFFF, 5'd31, 1'b1, 1'b0);
    check3("clamp cfg", 1'b0, 8'd0, 5'd0);
    for (int k = 1; k <= 15; k++) bit_in(1'b1);
    check3("clamp 15 bits", 1'b0, 8'd0, 5'd15);
    bit_in(1'b1);
    check3("clamp 16 bits", 1'b1, 8'd1, 5'd16);

    // Async reset mid-stream discards partial progress and restores the default config.
    drive(1'b0, 1'b0, 1'b1, 16'h0072, 5'd7, 1'b1, 1'b0);
    for (int k = 6; k >= 1; k--) bit_in(def_bits[k]);
    check3("pre-reset 6 bits", 1'b0, 8'd1, 5'd6);
    #2;
    rst = 1'b0;
    #1;
    check3("async reset", 1'b0, 8'd0, 5'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    bit_in(1'b0);
    check3("post-reset 0", 1'b0, 8'd0, 5'd1);
    for (int k = 6; k >= 1; k--) bit_in(def_bits[k]);
    check3("post-reset 6 bits", 1'b0, 8'd0, 5'd7);
    bit_in(def_bits[0]);
    check3("post-reset full", 1'b1, 8'd1, 5'd7);

    // Config mid-stream: after 1,1,1,0 load len 0 -> 1, pattern 1; bit during cfg_we dropped.
    do_reset();
    for (int k = 6; k >= 3; k--) bit_in(def_bits[k]);
    check3("mid 4 bits", 1'b0, 8'd0, 5'd4);
    drive(1'b1, 1'b1, 1'b1, 16'h0001, 5'd0, 1'b1, 1'b0);
    check3("mid cfg", 1'b0, 8'd0, 5'd0);
    bit_in(1'b0);
    check3("mid bit 0", 1'b0, 8'd0, 5'd1);
    bit_in(1'b1);
    check3("mid bit 1", 1'b1, 8'd1, 5'd1);
    drive(1'b0, 1'b0, 1'b0, 16'h0, 5'd0, 1'b0, 1'b0);
    check3("mid idle", 1'b0, 8'd1, 5'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
